// File: rtl/fft_in_packer.sv
// Serial-to-parallel packer feeding the FFT butterfly array: gathers LANES complex samples
// per word, tags frame start/end words, and flags a sof that arrives mid-frame.
module fft_in_packer #(
  parameter int unsigned DW    = 11,
  parameter int unsigned LANES = 16,
  parameter int unsigned FRAME = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 din_valid_i,
  input  logic                 din_sof_i,
  input  logic signed [DW-1:0] din_r_i,
  input  logic signed [DW-1:0] din_q_i,
  output logic                 dout_valid_o,
  output logic signed [DW-1:0] dout_r_o [LANES],
  output logic signed [DW-1:0] dout_q_o [LANES],
  output logic                 dout_sof_o,
  output logic                 dout_eof_o,
  output logic                 frame_err_o
);

  localparam int unsigned WORDS = FRAME / LANES;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [LW-1:0] LaneLast = LW'(LANES - 1);
  localparam logic [WW-1:0] WordLast = WW'(WORDS - 1);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d, wr_lane;
  logic [WW-1:0]        word_q, word_d, wr_word;
  logic signed [DW-1:0] buf_r_q [LANES];
  logic signed [DW-1:0] buf_r_d [LANES];
  logic signed [DW-1:0] buf_q_q [LANES];
  logic signed [DW-1:0] buf_q_d [LANES];
  logic signed [DW-1:0] dout_r_q [LANES];
  logic signed [DW-1:0] dout_q_q [LANES];
  logic                 accept, done, err_d;
  logic                 valid_q, sof_q, eof_q, err_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    buf_r_d = buf_r_q;
    buf_q_d = buf_q_q;
    err_d   = 1'b0;
    done    = 1'b0;
    accept  = din_valid_i && (din_sof_i || (state_q == StCollect));
    // A sof always restarts at lane 0 / word 0, whatever the counters say.
    wr_lane = din_sof_i ? '0 : lane_q;
    wr_word = din_sof_i ? '0 : word_q;
    if (accept) begin
      err_d = din_sof_i && (state_q == StCollect);
      for (int i = 0; i < int'(LANES); i++) begin
        if (wr_lane == LW'(i)) begin
          buf_r_d[i] = din_r_i;
          buf_q_d[i] = din_q_i;
        end
      end
      if (wr_lane == LaneLast) begin
        done   = 1'b1;
        lane_d = '0;
        if (wr_word == WordLast) begin
          word_d  = '0;
          state_d = StIdle;
        end else begin
          word_d  = wr_word + WW'(1);
          state_d = StCollect;
        end
      end else begin
        lane_d  = wr_lane + LW'(1);
        word_d  = wr_word;
        state_d = StCollect;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        buf_r_q[i]  <= '0;
        buf_q_q[i]  <= '0;
        dout_r_q[i] <= '0;
        dout_q_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      buf_r_q <= buf_r_d;
      buf_q_q <= buf_q_d;
      valid_q <= done;
      sof_q   <= done && (wr_word == '0);
      eof_q   <= done && (wr_word == WordLast);
      err_q   <= err_d;
      // Load from the next-state buffer so the final lane lands in the same word.
      if (done) begin
        dout_r_q <= buf_r_d;
        dout_q_q <= buf_q_d;
      end
    end
  end

  assign dout_valid_o = valid_q;
  assign dout_sof_o   = sof_q;
  assign dout_eof_o   = eof_q;
  assign frame_err_o  = err_q;
  assign dout_r_o     = dout_r_q;
  assign dout_q_o     = dout_q_q;

endmodule

// File: tb/tb_fft_in_packer.sv
// Self-checking bench for fft_in_packer: directed frame scenarios plus random traffic,
// compared cycle by cycle against a sample-index reference model.
module tb_fft_in_packer;

  localparam int DW    = 11;
  localparam int LANES = 16;
  localparam int FRAME = 512;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 din_valid, din_sof;
  logic signed [DW-1:0] din_r, din_q;
  logic                 dout_valid, dout_sof, dout_eof, frame_err;
  logic signed [DW-1:0] dout_r [LANES];
  logic signed [DW-1:0] dout_q [LANES];

  fft_in_packer #(.DW(DW), .LANES(LANES), .FRAME(FRAME)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .din_valid_i (din_valid),
    .din_sof_i   (din_sof),
    .din_r_i     (din_r),
    .din_q_i     (din_q),
    .dout_valid_o(dout_valid),
    .dout_r_o    (dout_r),
    .dout_q_o    (dout_q),
    .dout_sof_o  (dout_sof),
    .dout_eof_o  (dout_eof),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes = 0;
  int errs    = 0;

  // Reference model: tracks the sample index within the current frame.
  bit                   m_in_frame;
  int                   m_n;
  bit                   m_valid, m_sof, m_eof, m_err;
  logic signed [DW-1:0] m_cur_r [LANES];
  logic signed [DW-1:0] m_cur_q [LANES];
  logic signed [DW-1:0] m_out_r [LANES];
  logic signed [DW-1:0] m_out_q [LANES];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_n        = 0;
    m_valid    = 1'b0;
    m_sof      = 1'b0;
    m_eof      = 1'b0;
    m_err      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      m_cur_r[i] = '0;
      m_cur_q[i] = '0;
      m_out_r[i] = '0;
      m_out_q[i] = '0;
    end
  endtask

  task automatic model_step(input bit v, input bit s, input logic signed [DW-1:0] r,
                            input logic signed [DW-1:0] q);
    m_valid = 1'b0;
    m_sof   = 1'b0;
    m_eof   = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      model_reset();
    end else if (v && (s || m_in_frame)) begin
      if (s) begin
        m_err      = m_in_frame;
        m_n        = 0;
        m_in_frame = 1'b1;
      end
      m_cur_r[m_n % LANES] = r;
      m_cur_q[m_n % LANES] = q;
      m_n++;
      if (m_n % LANES == 0) begin
        m_valid = 1'b1;
        m_sof   = (m_n == LANES);
        m_eof   = (m_n == FRAME);
        m_out_r = m_cur_r;
        m_out_q = m_cur_q;
        if (m_n == FRAME) m_in_frame = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("dout_valid", 32'(dout_valid), 32'(m_valid));
    check_val("dout_sof", 32'(dout_sof), 32'(m_sof));
    check_val("dout_eof", 32'(dout_eof), 32'(m_eof));
    check_val("frame_err", 32'(frame_err), 32'(m_err));
    for (int i = 0; i < LANES; i++) begin
      check_val($sformatf("dout_r[%0d]", i), 32'(dout_r[i]), 32'(m_out_r[i]));
      check_val($sformatf("dout_q[%0d]", i), 32'(dout_q[i]), 32'(m_out_q[i]));
    end
    if (dout_valid) strobes++;
    if (frame_err) errs++;
  endtask

  task automatic drive(input bit v, input bit s, input int r, input int q);
    @(negedge clk);
    din_valid = v;
    din_sof   = s;
    din_r     = DW'(r);
    din_q     = DW'(q);
    @(posedge clk);
    #1;
    model_step(v, s, din_r, din_q);
    check_outputs();
  endtask

  task automatic idle_garbage();
    drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
  endtask

  task automatic send_samples(input int first, input int last, input bit gaps);
    for (int n = first; n <= last; n++) begin
      drive(1'b1, n == 0, n, -n);
      if (gaps && (n % 5 == 4)) repeat (3) idle_garbage();
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din_r     = '0;
    din_q     = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) drive(1'b0, 1'b0, 0, 0);
    rst = 1'b0;

    // Plain frame, all back-to-back.
    strobes = 0; errs = 0;
    send_samples(0, FRAME - 1, 1'b0);
    check_val("a_strobes", 32'(strobes), 32'd32);
    check_val("a_errs", 32'(errs), 32'd0);

    // Same frame with 3-cycle stalls after every 5th sample.
    strobes = 0; errs = 0;
    send_samples(0, FRAME - 1, 1'b1);
    check_val("b_strobes", 32'(strobes), 32'd32);
    check_val("b_errs", 32'(errs), 32'd0);

    // sof violation after 10 samples, restart with value 100 in lane 0.
    strobes = 0; errs = 0;
    send_samples(0, 9, 1'b0);
    drive(1'b1, 1'b1, 100, -100);
    for (int n = 1; n < LANES; n++) drive(1'b1, 1'b0, n, -n);
    check_val("c_lane0", 32'(dout_r[0]), 32'(DW'(100)));
    check_val("c_sof", 32'(dout_sof), 32'd1);
    for (int n = LANES; n < FRAME; n++) drive(1'b1, 1'b0, n, -n);
    check_val("c_strobes", 32'(strobes), 32'd32);
    check_val("c_errs", 32'(errs), 32'd1);

    // Two frames back-to-back.
    strobes = 0; errs = 0;
    send_samples(0, FRAME - 1, 1'b0);
    send_samples(0, FRAME - 1, 1'b0);
    check_val("d_strobes", 32'(strobes), 32'd64);
    check_val("d_errs", 32'(errs), 32'd0);

    // Samples without sof after reset are discarded.
    strobes = 0; errs = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) drive(1'b1, 1'b0, n + 3, -n);
    check_val("e_nosof_strobes", 32'(strobes), 32'd0);

    // Asynchronous reset during word 7.
    send_samples(0, 7 * LANES + 4, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) drive(1'b1, 1'b0, 7, 7);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, n, n);
    strobes = 0; errs = 0;
    send_samples(0, FRAME - 1, 1'b0);
    check_val("e_strobes", 32'(strobes), 32'd32);
    check_val("e_errs", 32'(errs), 32'd0);

    // Random traffic with stalls and occasional mid-frame sof.
    for (int k = 0; k < 4000; k++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = m_in_frame ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5) == 0);
      drive(v, s, int'($urandom), int'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
